// File: rtl/lane_lock_ctrl.sv
// Lane lock supervisor: staggers lane sync-FSM enables, waits for and qualifies aggregate lock, and bounds retries.
// Optional macro LANE_MASK_EN adds i_lane_mask so that masked lanes count as locked and are never enabled.
module lane_lock_ctrl #(
  parameter int N_LANES        = 20,
  parameter int NB_WINDOW_CNT  = 11,
  parameter int NB_INVALID_CNT = 3,
  parameter int NB_TIMEOUT     = 16,
  parameter int NB_QUAL        = 8,
  parameter int NB_RETRY       = 3
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic                      i_signal_ok,
  input  logic [N_LANES-1:0]        i_lane_lock,
`ifdef LANE_MASK_EN
  input  logic [N_LANES-1:0]        i_lane_mask,
`endif
  input  logic [NB_WINDOW_CNT-1:0]  i_cfg_unlocked_limit,
  input  logic [NB_WINDOW_CNT-1:0]  i_cfg_locked_limit,
  input  logic [NB_INVALID_CNT-1:0] i_cfg_invalid_limit,
  input  logic [NB_TIMEOUT-1:0]     i_timeout_limit,
  input  logic [NB_QUAL-1:0]        i_qual_limit,
  input  logic [NB_RETRY-1:0]       i_retry_limit,
  input  logic                      i_clear_fail,
  output logic [N_LANES-1:0]        o_lane_enable,
  output logic [NB_WINDOW_CNT-1:0]  o_unlocked_limit,
  output logic [NB_WINDOW_CNT-1:0]  o_locked_limit,
  output logic [NB_INVALID_CNT-1:0] o_invalid_limit,
  output logic                      o_all_lock,
  output logic                      o_deskew_start,
  output logic                      o_lock_fail,
  output logic [NB_RETRY-1:0]       o_retry_count,
  output logic [2:0]                o_state
);

  localparam int NB_IDX = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENABLE    = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_QUALIFY   = 3'd3,
    S_LOCKED    = 3'd4,
    S_RESTART   = 3'd5,
    S_FAIL      = 3'd6
  } state_e;

  state_e                    state_q;
  logic [NB_IDX-1:0]         lane_idx_q;
  logic [N_LANES-1:0]        lane_en_q;
  logic [N_LANES-1:0]        mask_q;
  logic [NB_WINDOW_CNT-1:0]  unlocked_lim_q;
  logic [NB_WINDOW_CNT-1:0]  locked_lim_q;
  logic [NB_INVALID_CNT-1:0] invalid_lim_q;
  logic [NB_TIMEOUT-1:0]     timeout_q;
  logic [NB_QUAL-1:0]        qual_q;
  logic [NB_RETRY-1:0]       retry_q;
  logic                      all_lock_q;
  logic                      deskew_q;
  logic                      fail_q;

  logic adv;
  logic all_locked;

  assign adv = i_enable & i_valid;

`ifdef LANE_MASK_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mask_q <= '0;
    end else if (adv && state_q == S_IDLE) begin
      mask_q <= i_lane_mask;
    end
  end
`else
  assign mask_q = '0;
`endif

  // A masked lane is treated as permanently locked.
  assign all_locked = &(i_lane_lock | mask_q);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= S_IDLE;
      lane_idx_q     <= '0;
      lane_en_q      <= '0;
      unlocked_lim_q <= '0;
      locked_lim_q   <= '0;
      invalid_lim_q  <= '0;
      timeout_q      <= '0;
      qual_q         <= '0;
      retry_q        <= '0;
      all_lock_q     <= 1'b0;
      deskew_q       <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      deskew_q <= 1'b0;
      if (adv && state_q == S_IDLE) begin
        unlocked_lim_q <= i_cfg_unlocked_limit;
        locked_lim_q   <= i_cfg_locked_limit;
        invalid_lim_q  <= i_cfg_invalid_limit;
      end
      // Loss of signal overrides the enable/valid qualification.
      if (!i_signal_ok) begin
        state_q    <= S_IDLE;
        lane_idx_q <= '0;
        lane_en_q  <= '0;
        retry_q    <= '0;
        all_lock_q <= 1'b0;
        fail_q     <= 1'b0;
      end else if (adv) begin
        unique case (state_q)
          S_IDLE: begin
            state_q    <= S_ENABLE;
            lane_idx_q <= '0;
            lane_en_q  <= '0;
          end
          S_ENABLE: begin
            lane_en_q[lane_idx_q] <= ~mask_q[lane_idx_q];
            if (lane_idx_q == LAST_IDX) begin
              state_q   <= S_WAIT_LOCK;
              timeout_q <= '0;
            end else begin
              lane_idx_q <= lane_idx_q + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (all_locked) begin
              state_q <= S_QUALIFY;
              qual_q  <= '0;
            end else if (timeout_q == i_timeout_limit) begin
              state_q   <= S_RESTART;
              lane_en_q <= '0;
            end else begin
              timeout_q <= timeout_q + 1'b1;
            end
          end
          S_QUALIFY: begin
            // Timeout counter keeps its value so a flickering lane cannot extend the search.
            if (!all_locked) begin
              state_q <= S_WAIT_LOCK;
            end else if (qual_q == i_qual_limit) begin
              state_q    <= S_LOCKED;
              deskew_q   <= 1'b1;
              all_lock_q <= 1'b1;
              retry_q    <= '0;
            end else begin
              qual_q <= qual_q + 1'b1;
            end
          end
          S_LOCKED: begin
            retry_q <= '0;
            if (!all_locked) begin
              state_q    <= S_RESTART;
              lane_en_q  <= '0;
              all_lock_q <= 1'b0;
            end
          end
          S_RESTART: begin
            if (retry_q == i_retry_limit) begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end else begin
              retry_q    <= retry_q + 1'b1;
              state_q    <= S_ENABLE;
              lane_idx_q <= '0;
            end
          end
          S_FAIL: begin
            lane_en_q <= '0;
            if (i_clear_fail) begin
              state_q <= S_IDLE;
              retry_q <= '0;
              fail_q  <= 1'b0;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            lane_en_q <= '0;
          end
        endcase
      end
    end
  end

  assign o_lane_enable    = lane_en_q;
  assign o_unlocked_limit = unlocked_lim_q;
  assign o_locked_limit   = locked_lim_q;
  assign o_invalid_limit  = invalid_lim_q;
  assign o_all_lock       = all_lock_q;
  assign o_deskew_start   = deskew_q;
  assign o_lock_fail      = fail_q;
  assign o_retry_count    = retry_q;
  assign o_state          = state_q;

endmodule

// File: tb/tb_lane_lock_ctrl.sv
// Self-checking bench for lane_lock_ctrl: vector table for bring-up, hand sequences for restart, timeout, overrides.
// Build with LANE_MASK_EN defined to also exercise the lane mask.
module tb_lane_lock_ctrl;
  localparam int NL = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_enable, i_valid, i_signal_ok, i_clear_fail;
  logic [NL-1:0]   i_lane_lock;
  logic [NL-1:0]   i_lane_mask;
  logic [10:0]     cfg_unl, cfg_lck;
  logic [2:0]      cfg_inv;
  logic [15:0]     timeout_lim;
  logic [7:0]      qual_lim;
  logic [2:0]      retry_lim;
  logic [NL-1:0]   o_lane_enable;
  logic [10:0]     o_unlocked_limit, o_locked_limit;
  logic [2:0]      o_invalid_limit;
  logic            o_all_lock, o_deskew_start, o_lock_fail;
  logic [2:0]      o_retry_count;
  logic [2:0]      o_state;

  always #5 clk = ~clk;

  lane_lock_ctrl dut (
    .i_clock              (clk),
    .i_reset_n            (rst_n),
    .i_enable             (i_enable),
    .i_valid              (i_valid),
    .i_signal_ok          (i_signal_ok),
    .i_lane_lock          (i_lane_lock),
`ifdef LANE_MASK_EN
    .i_lane_mask          (i_lane_mask),
`endif
    .i_cfg_unlocked_limit (cfg_unl),
    .i_cfg_locked_limit   (cfg_lck),
    .i_cfg_invalid_limit  (cfg_inv),
    .i_timeout_limit      (timeout_lim),
    .i_qual_limit         (qual_lim),
    .i_retry_limit        (retry_lim),
    .i_clear_fail         (i_clear_fail),
    .o_lane_enable        (o_lane_enable),
    .o_unlocked_limit     (o_unlocked_limit),
    .o_locked_limit       (o_locked_limit),
    .o_invalid_limit      (o_invalid_limit),
    .o_all_lock           (o_all_lock),
    .o_deskew_start       (o_deskew_start),
    .o_lock_fail          (o_lock_fail),
    .o_retry_count        (o_retry_count),
    .o_state              (o_state)
  );

  typedef struct {
    logic [2:0]    st;
    logic [NL-1:0] en;
    logic          al;
    logic          ds;
    logic          fl;
    logic [2:0]    rt;
  } exp_t;

  typedef struct {
    logic          valid;
    logic          enable;
    logic [NL-1:0] lock;
    exp_t          e;
  } vec_t;

  exp_t          sb[$];
  vec_t          tv[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            step_no = 0;
  logic [NL-1:0] mask_tb = '0;
  logic [NL-1:0] all1 = '1;
  logic [NL-1:0] part;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, req);
    end
  endtask

  function automatic exp_t mk(input int st, input logic [NL-1:0] en, input logic al,
                              input logic ds, input logic fl, input int rt);
    exp_t e;
    e.st = 3'(st);
    e.en = en;
    e.al = al;
    e.ds = ds;
    e.fl = fl;
    e.rt = 3'(rt);
    return e;
  endfunction

  function automatic vec_t vec(input logic v, input logic en, input logic [NL-1:0] lk, input exp_t e);
    vec_t r;
    r.valid  = v;
    r.enable = en;
    r.lock   = lk;
    r.e      = e;
    return r;
  endfunction

  // Lanes 0..k-1 enabled, minus masked lanes.
  function automatic logic [NL-1:0] fill(input int k);
    logic [NL-1:0] f;
    f = '0;
    for (int i = 0; i < k; i++) f[i] = 1'b1;
    return f & ~mask_tb;
  endfunction

  task automatic tick(input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    got = sb.pop_front();
    chk("state",    32'(o_state),        32'(got.st));
    chk("lane_en",  32'(o_lane_enable),  32'(got.en));
    chk("all_lock", 32'(o_all_lock),     32'(got.al));
    chk("deskew",   32'(o_deskew_start), 32'(got.ds));
    chk("fail",     32'(o_lock_fail),    32'(got.fl));
    chk("retry",    32'(o_retry_count),  32'(got.rt));
  endtask

  task automatic do_enable(input int rt);
    for (int k = 1; k <= NL; k++) tick(mk((k == NL) ? 2 : 1, fill(k), 1'b0, 1'b0, 1'b0, rt));
  endtask

  task automatic chk_cfg(input logic [10:0] u, input logic [10:0] l, input logic [2:0] iv);
    chk("cfg_unlocked", 32'(o_unlocked_limit), 32'(u));
    chk("cfg_locked",   32'(o_locked_limit),   32'(l));
    chk("cfg_invalid",  32'(o_invalid_limit),  32'(iv));
  endtask

  initial begin
    i_enable = 1'b1; i_valid = 1'b1; i_signal_ok = 1'b1; i_clear_fail = 1'b0;
    i_lane_lock = '0; i_lane_mask = '0;
    cfg_unl = 11'h5A5; cfg_lck = 11'h123; cfg_inv = 3'd5;
    timeout_lim = 16'd1000; qual_lim = 8'd8; retry_lim = 3'd2;
    part = all1;
    part[NL-1] = 1'b0;

    // Reset state
    #12;
    chk("rst_state",    32'(o_state),        32'd0);
    chk("rst_lane_en",  32'(o_lane_enable),  32'd0);
    chk("rst_all_lock", 32'(o_all_lock),     32'd0);
    chk("rst_deskew",   32'(o_deskew_start), 32'd0);
    chk("rst_fail",     32'(o_lock_fail),    32'd0);
    chk("rst_retry",    32'(o_retry_count),  32'd0);
    chk_cfg(11'd0, 11'd0, 3'd0);
    rst_n = 1'b1;

    // Bring-up table with valid/enable stalls in ENABLE, WAIT_LOCK and QUALIFY
    tv.push_back(vec(1'b1, 1'b1, '0, mk(1, '0, 0, 0, 0, 0)));
    for (int k = 1; k <= NL; k++) begin
      tv.push_back(vec(1'b1, 1'b1, '0, mk((k == NL) ? 2 : 1, fill(k), 0, 0, 0, 0)));
      if (k == 7)  tv.push_back(vec(1'b0, 1'b1, '0, mk(1, fill(7), 0, 0, 0, 0)));
      if (k == 13) tv.push_back(vec(1'b1, 1'b0, '0, mk(1, fill(13), 0, 0, 0, 0)));
    end
    for (int w = 0; w < 5; w++) tv.push_back(vec(1'b1, 1'b1, part, mk(2, fill(NL), 0, 0, 0, 0)));
    tv.push_back(vec(1'b0, 1'b1, all1, mk(2, fill(NL), 0, 0, 0, 0)));
    tv.push_back(vec(1'b1, 1'b1, all1, mk(3, fill(NL), 0, 0, 0, 0)));
    for (int q = 0; q < 8; q++) begin
      tv.push_back(vec(1'b1, 1'b1, all1, mk(3, fill(NL), 0, 0, 0, 0)));
      if (q == 3) tv.push_back(vec(1'b0, 1'b1, '0, mk(3, fill(NL), 0, 0, 0, 0)));
    end
    tv.push_back(vec(1'b1, 1'b1, all1, mk(4, fill(NL), 1, 1, 0, 0)));
    tv.push_back(vec(1'b1, 1'b1, all1, mk(4, fill(NL), 1, 0, 0, 0)));
    for (int i = 0; i < tv.size(); i++) begin
      i_valid     = tv[i].valid;
      i_enable    = tv[i].enable;
      i_lane_lock = tv[i].lock;
      tick(tv[i].e);
    end
    chk_cfg(11'h5A5, 11'h123, 3'd5);

    // Config changes outside IDLE must not reach the outputs
    cfg_unl = 11'h0F0; cfg_lck = 11'h70F; cfg_inv = 3'd2;
    i_valid = 1'b1; i_enable = 1'b1;

    // Lane 7 drops in LOCKED, RESTART holds through a valid gap, then restagger
    i_lane_lock = all1; i_lane_lock[7] = 1'b0;
    tick(mk(5, '0, 0, 0, 0, 0));
    i_lane_lock = all1; i_valid = 1'b0;
    tick(mk(5, '0, 0, 0, 0, 0));
    i_valid = 1'b1;
    tick(mk(1, '0, 0, 0, 0, 1));
    do_enable(1);
    tick(mk(3, fill(NL), 0, 0, 0, 1));
    for (int q = 0; q < 4; q++) tick(mk(3, fill(NL), 0, 0, 0, 1));
    // Flicker at qual count 4
    i_lane_lock[12] = 1'b0;
    tick(mk(2, fill(NL), 0, 0, 0, 1));
    i_lane_lock = all1;
    tick(mk(3, fill(NL), 0, 0, 0, 1));
    for (int q = 0; q < 8; q++) tick(mk(3, fill(NL), 0, 0, 0, 1));
    tick(mk(4, fill(NL), 1, 1, 0, 0));
    chk_cfg(11'h5A5, 11'h123, 3'd5);

    // Signal loss forces IDLE even without valid, then three timeouts into FAIL
    i_signal_ok = 1'b0; i_valid = 1'b0;
    tick(mk(0, '0, 0, 0, 0, 0));
    i_signal_ok = 1'b1; i_valid = 1'b1;
    timeout_lim = 16'd100; retry_lim = 3'd2;
    i_lane_lock = all1; i_lane_lock[3] = 1'b0;
    tick(mk(1, '0, 0, 0, 0, 0));
    chk_cfg(11'h0F0, 11'h70F, 3'd2);
    for (int r = 0; r <= 2; r++) begin
      do_enable(r);
      for (int c = 0; c < 100; c++) tick(mk(2, fill(NL), 0, 0, 0, r));
      tick(mk(5, '0, 0, 0, 0, r));
      if (r < 2) tick(mk(1, '0, 0, 0, 0, r + 1));
      else       tick(mk(6, '0, 0, 0, 1, 2));
    end
    tick(mk(6, '0, 0, 0, 1, 2));
    i_clear_fail = 1'b1;
    tick(mk(0, '0, 0, 0, 0, 0));
    i_clear_fail = 1'b0;

    // Signal loss mid-ENABLE
    i_lane_lock = '0; timeout_lim = 16'd1000;
    tick(mk(1, '0, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++) tick(mk(1, fill(k), 0, 0, 0, 0));
    i_signal_ok = 1'b0; i_valid = 1'b0; i_enable = 1'b0;
    tick(mk(0, '0, 0, 0, 0, 0));
    i_signal_ok = 1'b1; i_valid = 1'b1; i_enable = 1'b1;
    tick(mk(1, '0, 0, 0, 0, 0));
    do_enable(0);
    for (int c = 0; c < 10; c++) tick(mk(2, fill(NL), 0, 0, 0, 0));

    // Asynchronous reset mid-WAIT_LOCK
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state",   32'(o_state),       32'd0);
    chk("arst_lane_en", 32'(o_lane_enable), 32'd0);
    chk_cfg(11'd0, 11'd0, 3'd0);
    #2 rst_n = 1'b1;

    // Zero limits: timeout fires at once, retry limit 0 fails on first RESTART, qual 0 locks at once
    timeout_lim = 16'd0; retry_lim = 3'd0; qual_lim = 8'd0;
    tick(mk(1, '0, 0, 0, 0, 0));
    do_enable(0);
    tick(mk(5, '0, 0, 0, 0, 0));
    tick(mk(6, '0, 0, 0, 1, 0));
    i_clear_fail = 1'b1;
    tick(mk(0, '0, 0, 0, 0, 0));
    i_clear_fail = 1'b0;
    i_lane_lock = all1;
    tick(mk(1, '0, 0, 0, 0, 0));
    do_enable(0);
    tick(mk(3, fill(NL), 0, 0, 0, 0));
    tick(mk(4, fill(NL), 1, 1, 0, 0));

`ifdef LANE_MASK_EN
    // Lanes 18-19 masked and never locking
    i_signal_ok = 1'b0;
    tick(mk(0, '0, 0, 0, 0, 0));
    i_signal_ok = 1'b1;
    qual_lim = 8'd8;
    i_lane_mask = '0; i_lane_mask[18] = 1'b1; i_lane_mask[19] = 1'b1;
    mask_tb = i_lane_mask;
    i_lane_lock = ~i_lane_mask;
    tick(mk(1, '0, 0, 0, 0, 0));
    do_enable(0);
    tick(mk(3, fill(NL), 0, 0, 0, 0));
    for (int q = 0; q < 8; q++) tick(mk(3, fill(NL), 0, 0, 0, 0));
    tick(mk(4, fill(NL), 1, 1, 0, 0));
    chk("mask_hi_en", 32'(o_lane_enable[19:18]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lane_lock_ctrl.md
Name: lane_lock_ctrl

Overview:
- Supervises the per-lane sync-header block-sync FSMs of the 100GbE PCS receive path (N_LANES PCS lanes).
- Distributes lock-search configuration, enables lane FSMs in a staggered sequence and waits for aggregate lock.
- Pulses deskew start once all lanes hold lock for a qualification window; restarts the search on loss or timeout, with a bounded retry count.
- Sits between the per-lane block-sync instances and the lane deskew / reorder stage.

Parameters:
- N_LANES, 20, number of PCS lanes supervised.
- NB_WINDOW_CNT, 11, width of sync-FSM timer limits passed through.
- NB_INVALID_CNT, 3, width of invalid-sync-header limit passed through.
- NB_TIMEOUT, 16, width of lock-wait timeout counter.
- NB_QUAL, 8, width of lock-qualification counter.
- NB_RETRY, 3, width of retry counter.

Ports:
- i_clock, in, 1, system clock.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_enable, in, 1, global enable; 0 freezes all state and counters.
- i_valid, in, 1, datapath valid; all counters and FSM advance only when i_enable && i_valid.
- i_signal_ok, in, 1, PMA signal detect.
- i_lane_lock, in, N_LANES, block_lock from each lane sync FSM.
- i_cfg_unlocked_limit, in, NB_WINDOW_CNT, unlocked timer limit request.
- i_cfg_locked_limit, in, NB_WINDOW_CNT, locked timer limit request.
- i_cfg_invalid_limit, in, NB_INVALID_CNT, invalid-SH limit request.
- i_timeout_limit, in, NB_TIMEOUT, valid cycles allowed in WAIT_LOCK.
- i_qual_limit, in, NB_QUAL, valid cycles all lanes must stay locked before LOCKED.
- i_retry_limit, in, NB_RETRY, restarts allowed before FAIL.
- i_clear_fail, in, 1, exits FAIL to IDLE.
- o_lane_enable, out, N_LANES, enable to each lane sync FSM.
- o_unlocked_limit / o_locked_limit, out, NB_WINDOW_CNT, configuration driven to all lanes.
- o_invalid_limit, out, NB_INVALID_CNT, configuration driven to all lanes.
- o_all_lock, out, 1, high in LOCKED.
- o_deskew_start, out, 1, single-cycle pulse on entry to LOCKED.
- o_lock_fail, out, 1, high in FAIL.
- o_retry_count, out, NB_RETRY, current retry count.
- o_state, out, 3, one-hot-encoded-free state code (IDLE=0, ENABLE=1, WAIT_LOCK=2, QUALIFY=3, LOCKED=4, RESTART=5, FAIL=6).

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; all outputs 0; config outputs 0; counters 0.
- All transitions below are evaluated only when i_enable && i_valid, except i_signal_ok=0, which forces IDLE synchronously on any clock edge, zeroes o_lane_enable and clears the retry count.
- IDLE: latch i_cfg_* into the config output registers (config is stable outside IDLE). If i_signal_ok=1, go to ENABLE with lane_idx=0.
- ENABLE: set o_lane_enable[lane_idx] each valid cycle and increment lane_idx. After lane N_LANES-1 is set, go to WAIT_LOCK and clear the timeout counter. Takes exactly N_LANES valid cycles.
- WAIT_LOCK: the timeout counter increments each valid cycle.
  - If &i_lane_lock, go to QUALIFY and clear the qual counter.
  - Else, if the timeout counter equals i_timeout_limit, go to RESTART.
  - Lock has priority over timeout when both occur in the same cycle.
- QUALIFY: the qual counter increments while &i_lane_lock.
  - Any lane dropping returns to WAIT_LOCK without clearing the timeout counter.
  - When the qual counter equals i_qual_limit, go to LOCKED and pulse o_deskew_start for one clock.
- LOCKED: o_all_lock=1 and the retry count clears to 0. Any lane dropping sends the FSM to RESTART.
- RESTART: o_lane_enable=0 for exactly one valid cycle.
  - If retry count == i_retry_limit, go to FAIL.
  - Else increment the retry count and go to ENABLE with lane_idx=0.
- FAIL: o_lock_fail=1 and o_lane_enable=0. i_clear_fail=1 goes to IDLE and clears the retry count.
- Limits of 0: timeout or qual fires on the first evaluated cycle. i_retry_limit=0 means the first RESTART enters FAIL.
- Counters saturate only by FSM exit; no wrap-around is reachable.

Optional Feature:
- Macro: LANE_MASK_EN.
- Defined:
  - Adds input i_lane_mask[N_LANES-1:0]; a masked lane (bit=1) counts as locked for all aggregate checks.
  - A masked lane is skipped in ENABLE: its enable stays 0 while it still consumes its stagger cycle.
  - The mask is sampled in IDLE only.
- Undefined: no port; all lanes are required.

Test Plan:
- Reset, then i_signal_ok=1 with all lanes locking 5 cycles after enable → o_lane_enable fills one bit per valid cycle over 20 cycles; o_deskew_start pulses once after qual=8; o_all_lock=1; o_state=4.
- Lane 7 lock drops in LOCKED → RESTART with enables 0 for one valid cycle, then restaggered ENABLE; o_retry_count=1.
- i_timeout_limit=100, lane 3 never locks, i_retry_limit=2 → three timeouts, then o_lock_fail=1; i_clear_fail returns to IDLE with retry count 0.
- Lane flickers during QUALIFY at qual count 4 → returns to WAIT_LOCK; no deskew pulse until 8 uninterrupted locked cycles.
- i_signal_ok deasserted mid-ENABLE, and i_reset_n asserted mid-WAIT_LOCK → immediate IDLE with all enables 0; i_valid=0 gaps stall every counter exactly.
- With LANE_MASK_EN defined and lanes 18–19 masked, those lanes never lock → reaches LOCKED; o_lane_enable[19:18]=0 throughout.
